// File: rtl/sr_pkg.sv
// sr_pkg: shared types and helpers for the S/R drive sequencer.
//   sr_state_t : sequencer FSM states
//   SR_CNT_W   : width of the pulse/gap interval counter
//   sr_masks() : per-channel set/reset decision from target and shadow state
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } sr_state_t;

  localparam int SR_CNT_W = 8;

  typedef struct packed {
    logic set_m;
    logic rst_m;
  } sr_mask_t;

  // Set only bits going 0->1, reset only bits going 1->0. The two results
  // cannot both be 1 for the same channel, which is what keeps S=R=1 away
  // from the flop bank.
  function automatic sr_mask_t sr_masks(input logic target, input logic shadow);
    sr_mask_t m;
    m.set_m = target & ~shadow;
    m.rst_m = ~target & shadow;
    return m;
  endfunction

endpackage

// File: rtl/sr_drive_sequencer_if.sv
// sr_drive_sequencer_if: request handshake between control logic and the
// sequencer.
//   req_valid  : requester has a target state to apply
//   req_target : requested Q state per channel (N bits)
//   req_ready  : sequencer idle and able to accept
// Modports: master = requester, slave = sequencer.
interface sr_drive_sequencer_if #(
  parameter int N = 4
);
  logic         req_valid;
  logic [N-1:0] req_target;
  logic         req_ready;

  modport master (output req_valid, output req_target, input req_ready);
  modport slave  (input req_valid, input req_target, output req_ready);
endinterface

// File: rtl/sr_pulse_timer.sv
// sr_pulse_timer: 8-bit loadable down-counter timing both the PULSE and GAP
// intervals. Counts down to zero and parks there until reloaded.
//   Clk, Rst  : clock, asynchronous active-high reset
//   load      : load load_val this cycle (wins over counting)
//   load_val  : value to load
//   value     : current count
//   zero      : registered flag, high when value is zero
module sr_pulse_timer
  import sr_pkg::*;
(
  input  logic                Clk,
  input  logic                Rst,
  input  logic                load,
  input  logic [SR_CNT_W-1:0] load_val,
  output logic [SR_CNT_W-1:0] value,
  output logic                zero
);

  // Counter and its zero flag; the flag is computed one step ahead so it
  // is a flop output rather than a comparator on value.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      value <= {SR_CNT_W{1'b0}};
      zero  <= 1'b1;
    end else if (load) begin
      value <= load_val;
      zero  <= (load_val == {SR_CNT_W{1'b0}});
    end else if (!zero) begin
      value <= value - {{(SR_CNT_W-1){1'b0}}, 1'b1};
      zero  <= (value == {{(SR_CNT_W-1){1'b0}}, 1'b1});
    end else begin
      value <= value;
      zero  <= zero;
    end
  end

endmodule

// File: rtl/sr_drive_sequencer.sv
// sr_drive_sequencer: accepts target states for N S/R flops and drives
// time-qualified S/R pulses (PULSE_CYCLES long, then GAP_CYCLES idle) that
// never assert S and R on the same bit; keeps a shadow of expected Q.
//   Clk, Rst  : clock, asynchronous active-high reset
//   bus       : request handshake (slave modport)
//   S, R      : registered set/reset drive to the flop bank
//   busy      : high in PULSE or GAP
//   done      : one-cycle pulse when a request completes
//   shadow_q  : registered expected flop state
// Optional build macro SR_READBACK_EN adds Q_fb (flop bank feedback) and
// fb_err (sticky readback mismatch flag).
module sr_drive_sequencer
  import sr_pkg::*;
#(
  parameter int N            = 4,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1
) (
  input  logic                      Clk,
  input  logic                      Rst,
  sr_drive_sequencer_if.slave       bus,
  output logic [N-1:0]              S,
  output logic [N-1:0]              R,
  output logic                      busy,
  output logic                      done,
  output logic [N-1:0]              shadow_q
`ifdef SR_READBACK_EN
  ,
  input  logic [N-1:0]              Q_fb,
  output logic                      fb_err
`endif
);

  if (N < 1 || PULSE_CYCLES < 1 || PULSE_CYCLES > 255 ||
      GAP_CYCLES < 0 || GAP_CYCLES > 255) begin : g_param_check
    $error("sr_drive_sequencer: parameter out of legal range");
  end

  localparam logic                HAS_GAP    = (GAP_CYCLES > 0);
  localparam logic [SR_CNT_W-1:0] PULSE_LOAD = SR_CNT_W'(PULSE_CYCLES - 1);
  localparam logic [SR_CNT_W-1:0] GAP_LOAD   = HAS_GAP ? SR_CNT_W'(GAP_CYCLES - 1)
                                                       : {SR_CNT_W{1'b0}};

  sr_state_t           state_r, state_s;
  logic [N-1:0]        tgt_r, tgt_s;
  logic [N-1:0]        set_s, rst_s;
  logic [N-1:0]        s_s, r_s, shadow_s;
  logic                done_s, chk_r, chk_s, ready_r;
  logic                ld_s;
  logic [SR_CNT_W-1:0] ld_val_s, cnt_value_s;
  logic                cnt_zero_s, cnt_last_s;

  sr_pulse_timer u_timer (
    .Clk      (Clk),
    .Rst      (Rst),
    .load     (ld_s),
    .load_val (ld_val_s),
    .value    (cnt_value_s),
    .zero     (cnt_zero_s)
  );

  // An interval ends only when flag and count agree, so a single upset in
  // either counter flop cannot cut a pulse short.
  assign cnt_last_s    = cnt_zero_s & ~(|cnt_value_s);
  assign bus.req_ready = ready_r;

  // Per-channel set/reset masks for the presented target.
  always_comb begin
    sr_mask_t m;
    set_s = {N{1'b0}};
    rst_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      m        = sr_masks(bus.req_target[i], shadow_q[i]);
      set_s[i] = m.set_m;
      rst_s[i] = m.rst_m;
    end
  end

  // Next-state, next-output and timer-load decode.
  always_comb begin
    state_s  = state_r;
    tgt_s    = tgt_r;
    s_s      = S;
    r_s      = R;
    shadow_s = shadow_q;
    done_s   = 1'b0;
    chk_s    = 1'b0;
    ld_s     = 1'b0;
    ld_val_s = {SR_CNT_W{1'b0}};
    case (state_r)
      IDLE: begin
        s_s = {N{1'b0}};
        r_s = {N{1'b0}};
        if (bus.req_valid && ready_r) begin
          tgt_s = bus.req_target;
          if ((set_s | rst_s) == {N{1'b0}}) begin
            done_s = 1'b1;
          end else begin
            s_s      = set_s;
            r_s      = rst_s;
            state_s  = PULSE;
            ld_s     = 1'b1;
            ld_val_s = PULSE_LOAD;
          end
        end else begin
          state_s = IDLE;
        end
      end
      PULSE: begin
        if (cnt_last_s) begin
          s_s   = {N{1'b0}};
          r_s   = {N{1'b0}};
          chk_s = 1'b1;
          if (HAS_GAP) begin
            state_s  = GAP;
            ld_s     = 1'b1;
            ld_val_s = GAP_LOAD;
          end else begin
            state_s  = IDLE;
            shadow_s = tgt_r;
            done_s   = 1'b1;
          end
        end else begin
          state_s = PULSE;
        end
      end
      GAP: begin
        s_s = {N{1'b0}};
        r_s = {N{1'b0}};
        if (cnt_last_s) begin
          state_s  = IDLE;
          shadow_s = tgt_r;
          done_s   = 1'b1;
        end else begin
          state_s = GAP;
        end
      end
      default: begin
        state_s = IDLE;
        s_s     = {N{1'b0}};
        r_s     = {N{1'b0}};
      end
    endcase
  end

  // State and registered outputs; reset clears S/R immediately.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_r  <= IDLE;
      tgt_r    <= {N{1'b0}};
      S        <= {N{1'b0}};
      R        <= {N{1'b0}};
      shadow_q <= {N{1'b0}};
      done     <= 1'b0;
      busy     <= 1'b0;
      ready_r  <= 1'b1;
      chk_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      tgt_r    <= tgt_s;
      S        <= s_s;
      R        <= r_s;
      shadow_q <= shadow_s;
      done     <= done_s;
      busy     <= (state_s != IDLE);
      ready_r  <= (state_s == IDLE);
      chk_r    <= chk_s;
    end
  end

`ifdef SR_READBACK_EN
  // Sticky readback check in the first cycle after the pulse ends.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      fb_err <= 1'b0;
    end else if (chk_r && (Q_fb != tgt_r)) begin
      fb_err <= 1'b1;
    end else begin
      fb_err <= fb_err;
    end
  end
`else
  logic unused_chk_s;
  assign unused_chk_s = chk_r;
`endif

endmodule

// File: tb/tb_sr_drive_sequencer.sv
// Self-checking bench for sr_drive_sequencer (N=4, PULSE_CYCLES=2,
// GAP_CYCLES=1). Expected completions are queued when a request is driven
// and compared when the DUT raises done.
module tb_sr_drive_sequencer;

  localparam int N = 4;
  localparam int P = 2;
  localparam int G = 1;

  typedef struct {
    logic [N-1:0] set_m;
    logic [N-1:0] rst_m;
    logic [N-1:0] tgt;
    int           lat;
    int           pulses;
  } exp_t;

  logic         Clk;
  logic         Rst;
  logic [N-1:0] S, R, shadow_q;
  logic         busy, done;
  int           total;
  int           bad;
  logic [N-1:0] model_shadow;
  exp_t         exp_q[$];

  sr_drive_sequencer_if #(.N(N)) bus ();

`ifdef SR_READBACK_EN
  logic [N-1:0] q_fb;
  logic         fb_err;
  bit           fb_stuck;

  // Behavioural S/R flop bank; fb_stuck models a bank that never responds.
  always @(posedge Clk or posedge Rst) begin
    if (Rst) q_fb <= '0;
    else if (fb_stuck) q_fb <= '0;
    else q_fb <= (q_fb & ~R) | S;
  end
`endif

  sr_drive_sequencer #(.N(N), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .bus      (bus.slave),
    .S        (S),
    .R        (R),
    .busy     (busy),
    .done     (done),
    .shadow_q (shadow_q)
`ifdef SR_READBACK_EN
    ,
    .Q_fb     (q_fb),
    .fb_err   (fb_err)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one request, push its expectation, then monitor until done.
  task automatic do_req(input logic [N-1:0] tgt);
    exp_t e, got;
    int   act, match, lat;
    bit   overlap, seen;
    e.set_m  = tgt & ~model_shadow;
    e.rst_m  = ~tgt & model_shadow;
    e.tgt    = tgt;
    e.lat    = ((e.set_m | e.rst_m) == '0) ? 1 : 1 + P + G;
    e.pulses = ((e.set_m | e.rst_m) == '0) ? 0 : P;
    exp_q.push_back(e);
    model_shadow = tgt;
    @(negedge Clk);
    check("ready_before_req", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_target = tgt;
    @(posedge Clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_target = 4'($urandom_range(0, 15));
    act = 0; match = 0; lat = 0; overlap = 0; seen = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge Clk);
      if ((S | R) != '0) act++;
      if ((S | R) != '0 && S == e.set_m && R == e.rst_m) match++;
      if ((S & R) != '0) overlap = 1;
      if (c == 1 && e.pulses != 0) check("busy_in_pulse", {30'd0, busy, bus.req_ready}, 32'd2);
      if (done) begin seen = 1; lat = c; end
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      got = exp_q.pop_front();
      check("latency", lat, got.lat);
      check("shadow_at_done", {28'd0, shadow_q}, {28'd0, got.tgt});
      check("active_cycles", act, got.pulses);
      check("sr_pattern_cycles", match, got.pulses);
      check("no_s_and_r", {31'd0, overlap}, 32'd0);
      @(negedge Clk);
      check("done_one_cycle", {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    model_shadow = '0;
    bus.req_valid = 1'b0;
    bus.req_target = '0;
`ifdef SR_READBACK_EN
    fb_stuck = 0;
`endif
    Rst = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_S", {28'd0, S}, 32'd0);
    check("rst_R", {28'd0, R}, 32'd0);
    check("rst_shadow", {28'd0, shadow_q}, 32'd0);
    check("rst_done_busy", {30'd0, done, busy}, 32'd0);
    Rst = 1'b0;
    @(negedge Clk);
    check("ready_after_rst", {31'd0, bus.req_ready}, 32'd1);

    do_req(4'b1010);
    do_req(4'b0110);
    do_req(4'b0110);
    do_req(4'b1001);
    do_req(4'b0000);
    do_req(4'b1111);

    // Reset in the middle of a pulse must drop S/R without a clock edge.
    @(negedge Clk);
    bus.req_valid = 1'b1;
    bus.req_target = 4'b0000;
    @(posedge Clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge Clk);
    check("mid_pulse_R", {28'd0, R}, 32'hF);
    #2;
    Rst = 1'b1;
    #1;
    check("async_rst_S", {28'd0, S}, 32'd0);
    check("async_rst_R", {28'd0, R}, 32'd0);
    check("async_rst_shadow", {28'd0, shadow_q}, 32'd0);
    exp_q.delete();
    model_shadow = '0;
    @(negedge Clk);
    Rst = 1'b0;
    do_req(4'b0011);

`ifdef SR_READBACK_EN
    check("fb_err_clean", {31'd0, fb_err}, 32'd0);
    @(negedge Clk);
    Rst = 1'b1;
    fb_stuck = 1;
    @(negedge Clk);
    Rst = 1'b0;
    model_shadow = '0;
    do_req(4'b0001);
    check("fb_err_set", {31'd0, fb_err}, 32'd1);
    repeat (3) @(negedge Clk);
    check("fb_err_sticky", {31'd0, fb_err}, 32'd1);
    Rst = 1'b1;
    #1;
    check("fb_err_cleared", {31'd0, fb_err}, 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
`endif

    repeat (2) @(negedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
